// File: rtl/bitwise_or_unit_pkg.sv
// Shared definitions for the datapath logic elements (OR/AND/XOR/NOR).
package bitwise_or_unit_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : bitwise_or_unit_pkg

// File: rtl/bitwise_or_unit_or_bit_slice.sv
// Single-bit two-input OR, replicated across the word by the top level.
module or_bit_slice (
    input  logic a,
    input  logic b,
    output logic y
);

    // One bit of the result; no carry between slices.
    always_comb begin
        y = a | b;
    end

endmodule : or_bit_slice

// File: rtl/bitwise_or_unit.sv
// 32-bit bitwise OR for OR/ORI execution: combinational result and flags,
// plus a registered copy with valid tracking for the EX/MEM consumer.
module bitwise_or_unit
    import bitwise_or_unit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_ones,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid
);

    logic [WIDTH-1:0] or_p0;
    logic [WIDTH-1:0] out_q_p1;
    logic             vld_p1;

    // Stage p0: purely combinational OR, one slice per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        or_bit_slice u_slice (
            .a (input_a[i]),
            .b (input_b[i]),
            .y (or_p0[i])
        );
    end

    // Status flags follow the combinational result; reset never touches them.
    always_comb begin
        out      = or_p0;
        out_zero = ~|or_p0;
        out_ones = &or_p0;
    end

    // Stage p1: capture on valid cycles, hold data otherwise; reset wins over valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_q_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (in_valid) begin
            out_q_p1 <= or_p0;
            vld_p1   <= 1'b1;
        end else begin
            vld_p1   <= 1'b0;
        end
    end

    // Registered outputs.
    always_comb begin
        out_q       = out_q_p1;
        out_q_valid = vld_p1;
    end

endmodule : bitwise_or_unit

// File: tb/tb_bitwise_or_unit.sv
// Self-checking bench for bitwise_or_unit: directed vectors plus a
// behavioural model compared against the DUT on every falling edge.
module tb_bitwise_or_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic        in_valid = 1'b0;
    logic [31:0] out;
    logic        out_zero;
    logic        out_ones;
    logic [31:0] out_q;
    logic        out_q_valid;

    int errors = 0;
    int checks = 0;

    // Model state for the registered path.
    logic [31:0] exp_q = '0;
    logic        exp_v = 1'b0;
    bit          model_known = 1'b0;
    bit          done = 1'b0;

    bitwise_or_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .input_a     (input_a),
        .input_b     (input_b),
        .in_valid    (in_valid),
        .out         (out),
        .out_zero    (out_zero),
        .out_ones    (out_ones),
        .out_q       (out_q),
        .out_q_valid (out_q_valid)
    );

    always #10 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference OR built bit by bit from the truth table.
    function automatic logic [31:0] ref_or(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = (a[i] == 1'b1 || b[i] == 1'b1) ? 1'b1 : 1'b0;
        return r;
    endfunction

    // Model of the output register: updated from the values present at the edge.
    always @(posedge clock) begin
        if (reset == 1'b0) begin
            exp_q = 32'h0;
            exp_v = 1'b0;
            model_known = 1'b1;
        end else if (in_valid == 1'b1) begin
            exp_q = ref_or(input_a, input_b);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    end

    // Compare every falling edge: combinational outputs always, registered once defined.
    always @(negedge clock) begin
        if (!done) begin
            logic [31:0] e;
            e = ref_or(input_a, input_b);
            chk("model_out", out, e);
            chk("model_zero", {31'b0, out_zero}, {31'b0, (e == 32'h0)});
            chk("model_ones", {31'b0, out_ones}, {31'b0, (e == 32'hFFFF_FFFF)});
            if (model_known) begin
                chk("model_out_q", out_q, exp_q);
                chk("model_out_q_valid", {31'b0, out_q_valid}, {31'b0, exp_v});
            end
        end
    end

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Plan 1: zero operands, checked half a cycle later, reset still low.
        after_edge();
        input_a = 32'h0000_0000; input_b = 32'h0000_0000;
        #9;
        chk("p1_out", out, 32'h0000_0000);
        chk("p1_zero", {31'b0, out_zero}, 32'd1);
        chk("p1_ones", {31'b0, out_ones}, 32'd0);

        // Second reset edge, then reset state.
        after_edge();
        chk("reset_out_q", out_q, 32'h0);
        chk("reset_out_q_valid", {31'b0, out_q_valid}, 32'd0);

        // Plan 2: complementary nibbles give all ones (reset still low).
        input_a = 32'hF0F0_F0F0; input_b = 32'h0F0F_0F0F;
        #9;
        chk("p2_out", out, 32'hFFFF_FFFF);
        chk("p2_ones", {31'b0, out_ones}, 32'd1);
        chk("p2_zero", {31'b0, out_zero}, 32'd0);

        // Plan 3: mixed pattern and identical operands.
        after_edge();
        reset = 1'b1;
        input_a = 32'h1234_5678; input_b = 32'h8000_0001;
        #9;
        chk("p3_out", out, 32'h9234_5679);
        after_edge();
        input_a = 32'hA5A5_A5A5; input_b = 32'hA5A5_A5A5;
        #9;
        chk("p3_same", out, 32'hA5A5_A5A5);
        chk("p3_zero", {31'b0, out_zero}, 32'd0);

        // Plan 4: one-cycle capture, then hold with valid dropping.
        after_edge();
        input_a = 32'h00FF_0000; input_b = 32'h0000_FF00; in_valid = 1'b1;
        after_edge();
        chk("p4_out_q", out_q, 32'h00FF_FF00);
        chk("p4_valid", {31'b0, out_q_valid}, 32'd1);
        in_valid = 1'b0;
        input_a = 32'h1111_1111; input_b = 32'h2222_2222;
        after_edge();
        chk("p4_hold_q", out_q, 32'h00FF_FF00);
        chk("p4_hold_valid", {31'b0, out_q_valid}, 32'd0);

        // Plan 5: reset concurrent with valid; combinational path unaffected.
        input_a = 32'hDEAD_0000; input_b = 32'h0000_BEEF; in_valid = 1'b1; reset = 1'b0;
        after_edge();
        chk("p5_out_q", out_q, 32'h0);
        chk("p5_valid", {31'b0, out_q_valid}, 32'd0);
        chk("p5_out", out, 32'hDEAD_BEEF);
        reset = 1'b1;
        in_valid = 1'b0;

        // Plan 6: random operand pairs, random valid, checked by the compare process.
        for (int n = 0; n < 120; n++) begin
            after_edge();
            input_a  = $urandom;
            input_b  = $urandom;
            in_valid = 1'($urandom_range(0, 1));
        end
        after_edge();
        in_valid = 1'b0;
        after_edge();
        after_edge();

        done = 1'b1;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bitwise_or_unit
